// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one result per accepted op.
// Latency: 33 cycles from accept to the wen pulse (1 cycle for divide-by-zero / signed-overflow cases).
// Backpressure: busy holds execute stalled; start while busy is ignored, nothing is queued.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1data,
    input  logic [XLEN-1:0] rs2data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            wen,
    output logic [4:0]      rdaddr,
    output logic [XLEN-1:0] wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    // Architectural state
    state_t              r_state;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic                r_sign_a;
    logic                r_sign_b;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [XLEN-1:0]     r_op;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
    logic [2*XLEN-1:0]   r_acc;
    logic [4:0]          r_cnt;
    logic                r_busy;
    logic                r_wen;
    logic [4:0]          r_rdaddr;
    logic [XLEN-1:0]     r_wdata;

    // Accept-side decode
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_val;

    // Iteration datapath
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_shift;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_sub;
    logic [XLEN-1:0]     w_div_rem;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_acc_next;

    // Sign fixup and result select
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_result;

    // Operand signedness per op: MULH/DIV/REM treat both as signed, MULHSU only rs1.
    always_comb begin
        w_is_div   = funct3[2];
        w_a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                     (funct3 == F_DIV)  || (funct3 == F_REM);
        w_b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        w_sign_a   = w_a_signed & rs1data[XLEN-1];
        w_sign_b   = w_b_signed & rs2data[XLEN-1];
        w_mag_a    = w_sign_a ? ({XLEN{1'b0}} - rs1data) : rs1data;
        w_mag_b    = w_sign_b ? ({XLEN{1'b0}} - rs2data) : rs2data;
    end

    // Divide-by-zero and signed overflow are resolved at accept and skip the iteration.
    always_comb begin
        w_div_zero = w_is_div && (rs2data == {XLEN{1'b0}});
        w_div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                     (rs1data == MOST_NEG) && (rs2data == ALL_ONES);
        w_special  = w_div_zero || w_div_ovf;
        if (w_div_zero) begin
            w_special_val = funct3[1] ? rs1data : ALL_ONES;
        end else begin
            w_special_val = funct3[1] ? {XLEN{1'b0}} : MOST_NEG;
        end
    end

    // One iteration of shift-add multiply and restoring divide, selected by the latched op.
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current multiplier
        // bit (LSB of the lower half) is set, then shift the whole pair right by one.
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                     (r_acc[0] ? {1'b0, r_op} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

        // Divide: shift the next dividend bit (MSB of the lower half) into the remainder.
        // The remainder is always below the divisor, so the shifted value fits in 33 bits
        // and, when the subtract succeeds, the difference fits back in 32.
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_op});
        w_div_sub   = w_div_shift[XLEN-1:0] - r_op;
        w_div_rem   = w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
        w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ge};

        w_acc_next  = r_funct3[2] ? w_div_next : w_mul_next;
    end

    // Sign fixup on the final iteration's value so the result can be registered into DONE.
    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? ({(2*XLEN){1'b0}} - w_acc_next) : w_acc_next;
        w_quo  = (r_sign_a ^ r_sign_b) ? ({XLEN{1'b0}} - w_acc_next[XLEN-1:0])
                                       : w_acc_next[XLEN-1:0];
        w_rem  = r_sign_a ? ({XLEN{1'b0}} - w_acc_next[2*XLEN-1:XLEN])
                          : w_acc_next[2*XLEN-1:XLEN];
        w_result = w_prod[XLEN-1:0];
        case (r_funct3)
            F_MUL:                    w_result = w_prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:            w_result = w_quo;
            F_REM, F_REMU:            w_result = w_rem;
            default:                  w_result = w_prod[XLEN-1:0];
        endcase
    end

    // Control FSM with registered outputs: IDLE accepts, CALC iterates 32 times, DONE writes back.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'b000;
            r_rd     <= 5'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_op     <= {XLEN{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_wen    <= 1'b0;
            r_rdaddr <= 5'd0;
            r_wdata  <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wen <= 1'b0;
                    if (start) begin
                        r_funct3 <= funct3;
                        r_rd     <= rd_in;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_cnt    <= 5'd0;
                        r_busy   <= 1'b1;
                        // Divide keeps the dividend in the low half and the divisor aside;
                        // multiply keeps the multiplier in the low half and the multiplicand aside.
                        r_op     <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        if (w_special) begin
                            r_state  <= S_DONE;
                            r_wen    <= (rd_in != 5'd0);
                            r_rdaddr <= rd_in;
                            r_wdata  <= w_special_val;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        // Result is registered on the edge that enters DONE, so wen is
                        // visible for the whole DONE cycle.
                        r_state  <= S_DONE;
                        r_wen    <= (r_rd != 5'd0);
                        r_rdaddr <= r_rd;
                        r_wdata  <= w_result;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_wen   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wen   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign wen    = r_wen;
    assign rdaddr = r_rdaddr;
    assign wdata  = r_wdata;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a write-back scoreboard.
// Stimulus pushes expected writes; a negedge monitor pops and checks on every wen.
// Latency is checked as edges between accept and the cycle wen is observed.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1data;
    logic [31:0] rs2data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        wen;
    logic [4:0]  rdaddr;
    logic [31:0] wdata;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    muldiv_unit #(.XLEN(32)) dut (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1data (rs1data),
        .rs2data (rs2data),
        .rd_in   (rd_in),
        .busy    (busy),
        .wen     (wen),
        .rdaddr  (rdaddr),
        .wdata   (wdata)
    );

    always #5 clock = ~clock;

    // Rising edges seen so far
    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int unsigned acc_cyc;
        int unsigned delta;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write-back must match the oldest outstanding expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!rst && wen) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wen: got wen=1 rdaddr=%0d wdata=0x%0h, expected no write (t=%0t)",
                         rdaddr, wdata, $time);
            end else begin
                e = sb.pop_front();
                check("wb_rdaddr", 64'(rdaddr), 64'(e.rd));
                check("wb_wdata", 64'(wdata), 64'(e.data));
                check("wb_latency_edges", 64'(cyc - e.acc_cyc), 64'(e.delta));
            end
        end
    end

    // Drive an op for one edge; afterwards scramble the inputs to prove they were latched.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data,
                         input bit special, input bit push, output int unsigned acc);
        @(negedge clock);
        funct3  = f;
        rs1data = a;
        rs2data = b;
        rd_in   = rd;
        start   = 1'b1;
        @(posedge clock);
        #1;
        acc     = cyc;
        start   = 1'b0;
        rs1data = $urandom;
        rs2data = $urandom;
        funct3  = 3'($urandom_range(0, 7));
        rd_in   = 5'($urandom_range(0, 31));
        check("accept_busy", 64'(busy), 64'd1);
        if (push) sb.push_back('{rd, exp_data, acc, (special ? 0 : 32)});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input bit special);
        int unsigned acc;
        issue(f, a, b, rd, exp_data, special, 1'b1, acc);
        wait_idle(name);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1);
    end

    initial begin : stim
        int unsigned acc;
        rst     = 1'b1;
        start   = 1'b0;
        funct3  = 3'b000;
        rs1data = 32'd0;
        rs2data = 32'd0;
        rd_in   = 5'd0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_rdaddr", 64'(rdaddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        // MUL 7 * -3 with a cycle-by-cycle busy/wen trace
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 1'b1, acc);
        for (int k = 0; k <= 33; k++) begin
            @(negedge clock);
            check("mul_trace_busy", 64'(busy), 64'(k <= 32));
            check("mul_trace_wen", 64'(wen), 64'(k == 32));
        end

        // Directed results
        run_op("mulh",    MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
        run_op("mulhu",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",  MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0);
        run_op("div",     DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b0);
        run_op("rem",     REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b0);
        run_op("divu",    DIVU,   32'd100,       32'd7,         5'd11, 32'd14,        1'b0);
        run_op("remu",    REMU,   32'd100,       32'd7,         5'd12, 32'd2,         1'b0);
        run_op("mul_lo",  MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'd1,         1'b0);
        run_op("div_neg", DIV,    32'd5,         32'hFFFF_FFFD, 5'd18, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_neg", REM,    32'd5,         32'hFFFF_FFFD, 5'd19, 32'd2,         1'b0);

        // Special cases: one-cycle latency
        run_op("divu_z",  DIVU,   32'h0000_1234, 32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1);
        run_op("remu_z",  REMU,   32'h0000_1234, 32'd0,         5'd14, 32'h0000_1234, 1'b1);
        run_op("div_ovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1);
        run_op("rem_ovf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1);
        run_op("div_z",   DIV,    32'hFFFF_FFFB, 32'd0,         5'd22, 32'hFFFF_FFFF, 1'b1);

        // Start while busy must be ignored
        issue(DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 1'b1, acc);
        repeat (4) @(negedge clock);
        funct3  = MUL;
        rs1data = 32'd2;
        rs2data = 32'd2;
        rd_in   = 5'd4;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        wait_idle("ignored");
        repeat (3) @(negedge clock);
        check("ignored_single_wen", 64'(sb.size()), 64'd0);

        // rd=0: full latency, no write
        issue(MUL, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0, 1'b0, acc);
        for (int k = 0; k <= 33; k++) begin
            @(negedge clock);
            check("rd0_busy", 64'(busy), 64'(k <= 32));
            check("rd0_wen", 64'(wen), 64'd0);
        end

        // Reset abort 10 cycles into CALC
        issue(MUL, 32'h1234_5678, 32'd9, 5'd20, 32'd0, 1'b0, 1'b0, acc);
        repeat (11) @(negedge clock);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_wen", 64'(wen), 64'd0);
        check("abort_wdata", 64'(wdata), 64'd0);
        check("abort_rdaddr", 64'(rdaddr), 64'd0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            check("abort_no_wen", 64'(wen), 64'd0);
            check("abort_no_busy", 64'(busy), 64'd0);
        end

        // Fresh op after reset
        run_op("mul_after_rst", MUL, 32'd3, 32'd4, 5'd21, 32'd12, 1'b0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
